// File: rtl/demo_io_slave.sv
// demo_io_slave: Avalon-MM register block for push-buttons, slide switches and LEDs.
// Define DEMO_IO_IRQ_EN to build the MASK register and the key-press interrupt.
module demo_io_slave #(
  parameter int unsigned NUM_KEYS        = 3,
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned NUM_LED         = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_SW-1:0]   sw,
  output logic [NUM_LED-1:0]  led,
  output logic                irq
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] ADDR_LED  = 3'd0;
  localparam logic [2:0] ADDR_SW   = 3'd1;
  localparam logic [2:0] ADDR_KEY  = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_MASK = 3'd4;

  logic [NUM_KEYS-1:0] key_meta, key_sync;
  logic [NUM_SW-1:0]   sw_meta, sw_sync;
  logic [NUM_KEYS-1:0] pressed, key_db, key_db_q;
  logic [CNT_W-1:0]    cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_event, event_set, event_clr, mask;
  logic [DATA_W-1:0]   rd_data;
  logic                wr_led, wr_edge;
  logic                unused_wdata;

  assign unused_wdata = ^avs_writedata;

  // Two-flop synchronizers; keys idle released (high), switches idle low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= '1;
      key_sync <= '1;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  assign pressed = ~key_sync;

  // Per-key debounce: accept a new level only after it persists DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_db <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (pressed[i] == key_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          key_db[i] <= pressed[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign wr_led    = avs_write && (avs_address == ADDR_LED);
  assign wr_edge   = avs_write && (avs_address == ADDR_EDGE);
  assign event_set = key_db & ~key_db_q;
  assign event_clr = wr_edge ? avs_writedata[NUM_KEYS-1:0] : '0;

  // Sticky press events; a same-cycle set overrides the write-1-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_db_q  <= '0;
      key_event <= '0;
    end else begin
      key_db_q  <= key_db;
      key_event <= (key_event & ~event_clr) | event_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led <= '0;
    end else if (wr_led) begin
      led <= avs_writedata[NUM_LED-1:0];
    end
  end

`ifdef DEMO_IO_IRQ_EN
  logic wr_mask;
  assign wr_mask = avs_write && (avs_address == ADDR_MASK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_mask) mask <= avs_writedata[NUM_KEYS-1:0];
      irq <= |(key_event & mask);
    end
  end
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_data = '0;
    case (avs_address)
      ADDR_LED:  rd_data = DATA_W'(led);
      ADDR_SW:   rd_data = DATA_W'(sw_sync);
      ADDR_KEY:  rd_data = DATA_W'(key_db);
      ADDR_EDGE: rd_data = DATA_W'(key_event);
      ADDR_MASK: rd_data = DATA_W'(mask);
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_demo_io_slave.sv
// Bench for demo_io_slave: directed steps plus random bus/key/switch traffic against a queue-based model.
module tb_demo_io_slave;

  localparam int unsigned DC = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic [2:0]  key_n;
  logic [9:0]  sw;
  logic [9:0]  led;
  logic        irq;

  int tests = 0;
  int failed = 0;

  demo_io_slave #(.NUM_KEYS(3), .NUM_SW(10), .NUM_LED(10), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .key_n(key_n), .sw(sw), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: input histories as queues, debounce as a "last DC samples disagree" window
  logic [9:0]  m_led;
  logic [2:0]  m_db, m_db_prev, m_event, m_mask;
  logic        m_irq;
  logic [31:0] m_rdata;
  logic [2:0]  raw_q[$];
  logic [9:0]  sw_q[$];
  logic [2:0]  seen_q[$];

  task automatic model_reset();
    m_led = '0; m_db = '0; m_db_prev = '0; m_event = '0; m_mask = '0;
    m_irq = 1'b0; m_rdata = '0;
    raw_q.delete(); sw_q.delete(); seen_q.delete();
    raw_q.push_back(3'b000); raw_q.push_back(3'b000);
    sw_q.push_back(10'h000); sw_q.push_back(10'h000);
  endtask

  task automatic model_edge(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] wd);
    logic [2:0]  seen, nxt_db, clr;
    logic [9:0]  sw_seen;
    logic [31:0] rv;
    logic        all_diff;
    seen    = raw_q[raw_q.size()-2];
    sw_seen = sw_q[sw_q.size()-2];
    raw_q.push_back(~key_n);
    sw_q.push_back(sw);
    seen_q.push_back(seen);
    while (raw_q.size() > 4) void'(raw_q.pop_front());
    while (sw_q.size() > 4) void'(sw_q.pop_front());
    while (seen_q.size() > 16) void'(seen_q.pop_front());
    nxt_db = m_db;
    for (int k = 0; k < 3; k++) begin
      if (seen_q.size() >= DC) begin
        all_diff = 1'b1;
        for (int j = 0; j < int'(DC); j++)
          if (seen_q[seen_q.size()-1-j][k] == m_db[k]) all_diff = 1'b0;
        if (all_diff) nxt_db[k] = ~m_db[k];
      end
    end
    case (a)
      3'd0: rv = 32'(m_led);
      3'd1: rv = 32'(sw_seen);
      3'd2: rv = 32'(m_db);
      3'd3: rv = 32'(m_event);
`ifdef DEMO_IO_IRQ_EN
      3'd4: rv = 32'(m_mask);
`endif
      default: rv = '0;
    endcase
    if (rd) m_rdata = rv;
`ifdef DEMO_IO_IRQ_EN
    m_irq = |(m_event & m_mask);
`else
    m_irq = 1'b0;
`endif
    clr = (wr && a == 3'd3) ? wd[2:0] : 3'b000;
    m_event   = (m_event & ~clr) | (m_db & ~m_db_prev);
    m_db_prev = m_db;
    m_db      = nxt_db;
    if (wr && a == 3'd0) m_led = wd[9:0];
`ifdef DEMO_IO_IRQ_EN
    if (wr && a == 3'd4) m_mask = wd[2:0];
`endif
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] wd);
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
    @(posedge clk);
    model_edge(rd, wr, a, wd);
    #1;
    check("led", 32'(led), 32'(m_led));
    check("irq", 32'(irq), 32'(m_irq));
    check("rdata", avs_readdata, m_rdata);
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; key_n = 3'b111; sw = 10'h1A5;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", avs_readdata, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    idle(3);

    // Post-reset register readback
    for (int a = 0; a < 8; a++) begin
      tick(1'b1, 1'b0, 3'(a), 32'h0);
      check("reset_read", avs_readdata, (a == 1) ? 32'h1A5 : 32'h0);
    end

    // LED write and upper-bit masking
    tick(1'b0, 1'b1, 3'd0, 32'h0000_03FF);
    check("led_all_on", 32'(led), 32'h3FF);
    tick(1'b0, 1'b1, 3'd0, 32'hFFFF_F400);
    check("led_upper_ignored", 32'(led), 32'h0);
    tick(1'b1, 1'b0, 3'd0, 32'h0);
    check("led_readback", avs_readdata, 32'h0);

    // Short glitch on key 1 must be rejected
    key_n[1] = 1'b0;
    idle(3);
    key_n[1] = 1'b1;
    idle(8);
    tick(1'b1, 1'b0, 3'd2, 32'h0);
    check("glitch_key", avs_readdata, 32'h0);
    tick(1'b1, 1'b0, 3'd3, 32'h0);
    check("glitch_edge", avs_readdata, 32'h0);

    // Held press: KEY after 2+DC cycles, EDGE one cycle later
    key_n[1] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick(1'b1, 1'b0, (t == 8) ? 3'd3 : 3'd2, 32'h0);
      if (t == 6) check("key_before_accept", avs_readdata, 32'h0);
      if (t == 7) check("key_accepted", avs_readdata, 32'h2);
      if (t == 8) check("edge_after_accept", avs_readdata, 32'h2);
    end
    key_n[1] = 1'b1;
    idle(10);

`ifdef DEMO_IO_IRQ_EN
    tick(1'b0, 1'b1, 3'd3, 32'h7);
    tick(1'b0, 1'b1, 3'd4, 32'h2);
    key_n[1] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick(1'b1, 1'b0, 3'd3, 32'h0);
      if (t == 7) check("irq_before", 32'(irq), 32'h0);
      if (t == 8) begin
        check("irq_rise", 32'(irq), 32'h1);
        check("edge_for_irq", avs_readdata, 32'h2);
      end
    end
    key_n[1] = 1'b1;
    tick(1'b0, 1'b1, 3'd3, 32'h1);
    tick(1'b1, 1'b0, 3'd3, 32'h0);
    check("w1c_other_bit", avs_readdata, 32'h2);
    check("irq_held", 32'(irq), 32'h1);
    tick(1'b0, 1'b1, 3'd3, 32'h2);
    tick(1'b1, 1'b0, 3'd3, 32'h0);
    check("w1c_cleared", avs_readdata, 32'h0);
    check("irq_fall", 32'(irq), 32'h0);
    idle(10);
`else
    tick(1'b0, 1'b1, 3'd4, 32'h2);
    tick(1'b1, 1'b0, 3'd4, 32'h0);
    check("mask_absent", avs_readdata, 32'h0);
    check("irq_tied", 32'(irq), 32'h0);
`endif

    // Write-1-clear on the cycle a new press sets the bit: set wins
    tick(1'b0, 1'b1, 3'd3, 32'h7);
    key_n[0] = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      if (t == 7) tick(1'b0, 1'b1, 3'd3, 32'h1);
      else        idle(1);
    end
    tick(1'b1, 1'b0, 3'd3, 32'h0);
    check("set_beats_clear", avs_readdata & 32'h1, 32'h1);
    key_n[0] = 1'b1;
    idle(10);

    // Asynchronous reset mid-count on key 2, then full re-debounce
    sw = 10'h2AA;
    tick(1'b0, 1'b1, 3'd0, 32'h155);
    idle(2);
    tick(1'b1, 1'b0, 3'd1, 32'h0);
    check("sw_sync", avs_readdata, 32'h2AA);
    key_n[2] = 1'b0;
    idle(4);
    reset_n = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_rdata", avs_readdata, 32'h0);
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick(1'b1, 1'b0, (t == 8) ? 3'd3 : 3'd2, 32'h0);
      if (t == 6) check("arst_key_wait", avs_readdata, 32'h0);
      if (t == 7) check("arst_key_set", avs_readdata, 32'h4);
      if (t == 8) check("arst_edge_set", avs_readdata, 32'h4);
    end
    key_n[2] = 1'b1;
    idle(10);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5, 0) == 0) key_n = 3'($urandom);
      if ($urandom_range(7, 0) == 0) sw = 10'($urandom);
      tick(1'($urandom), 1'($urandom), 3'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
